// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single D-cache port between the load-miss refill requester
//   (port 0) and the LSQ-head store write-back requester (port 1). One
//   transaction is in flight at a time: IDLE latches the winner's request,
//   GRANT/REQ present it to the cache, WAIT collects the cache response and
//   RESP returns it to the requester that won.
//
//   Ports
//     clk, reset        clock; synchronous active-low reset
//     req0_*            load request in; req0_grant pulse; rsp0_* load data out
//     req1_*            store request in; req1_grant pulse; rsp1_* store ack out
//     cache_req_*       request to the D-cache (valid/ready handshake)
//     cache_resp_*      D-cache response / write ack
//     busy              high whenever a transaction is in progress
//
//   Build option
//     DCACHE_ARB_RR_EN  defined: round-robin on conflict (port 0 wins the
//                       first conflict); undefined: port 0 always wins.
module dcache_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              req0_grant,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [TAG_W-1:0]  rsp0_tag,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              req1_grant,
  output logic              rsp1_valid,
  output logic [TAG_W-1:0]  rsp1_tag,
  output logic              cache_req_valid,
  input  logic              cache_req_ready,
  output logic              cache_req_we,
  output logic [ADDR_W-1:0] cache_req_addr,
  output logic [DATA_W-1:0] cache_req_wdata,
  input  logic              cache_resp_valid,
  input  logic [DATA_W-1:0] cache_resp_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] lat_rdata;
  logic [TAG_W-1:0]  lat_tag;
  logic              lat_we;     // also identifies the winner: 1 = port 1
  logic              any_req;
  logic              pick1;

  assign any_req = req0_valid | req1_valid;

`ifdef DCACHE_ARB_RR_EN
  // last_winner only moves on a conflict; reset value 1 lets port 0 take
  // the first conflict.
  logic last_winner;
  logic conflict;

  always_comb begin
    conflict = req0_valid & req1_valid;
    pick1    = conflict ? ~last_winner : req1_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_winner <= 1'b1;
    end else if (state == IDLE && conflict) begin
      last_winner <= pick1;
    end
  end
`else
  always_comb begin
    pick1 = ~req0_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rdata <= '0;
      lat_tag   <= '0;
      lat_we    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        lat_addr  <= pick1 ? req1_addr : req0_addr;
        lat_wdata <= pick1 ? req1_data : '0;
        lat_tag   <= pick1 ? req1_tag  : req0_tag;
        lat_we    <= pick1;
      end
      if (state == WAIT && cache_resp_valid) begin
        lat_rdata <= cache_resp_data;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    req0_grant      = 1'b0;
    req1_grant      = 1'b0;
    rsp0_valid      = 1'b0;
    rsp1_valid      = 1'b0;
    cache_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = GRANT;
      end
      GRANT: begin
        req0_grant      = ~lat_we;
        req1_grant      = lat_we;
        cache_req_valid = 1'b1;
        state_nxt       = cache_req_ready ? WAIT : REQ;
      end
      REQ: begin
        cache_req_valid = 1'b1;
        if (cache_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (cache_resp_valid) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~lat_we;
        rsp1_valid = lat_we;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cache_req_we    = lat_we;
  assign cache_req_addr  = lat_addr;
  assign cache_req_wdata = lat_wdata;
  assign rsp0_data       = lat_rdata;
  assign rsp0_tag        = lat_tag;
  assign rsp1_tag        = lat_tag;
  assign busy            = (state != IDLE);

endmodule
